// File: rtl/bsearch_pkg.sv
// rtl/bsearch_pkg.sv - shared types and midpoint helper for the binary-search engine
package bsearch_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, DONE} state_t;

    typedef enum logic [1:0] {LT, EQ, GT} cmp_t;

    // Midpoint of the half-open window [lo,hi); 32-bit arithmetic so lo+hi never overflows
    function automatic logic [31:0] calc_mid(input logic [31:0] lo, input logic [31:0] hi);
        calc_mid = (lo + hi) >> 1;
    endfunction

endpackage

// File: rtl/bsearch_engine_ctrl.sv
// rtl/bsearch_engine_ctrl.sv - search sequencer FSM with RAM read-latency wait counter
module bsearch_engine_ctrl
    import bsearch_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_start,
    input  logic   i_empty,
    input  logic   i_eq,
    input  logic   i_mode,
    output state_t o_state,
    output logic   o_busy,
    output logic   o_done
);

    // WAIT lasts RD_LAT-1 cycles; counter counts down to zero before CMP
    localparam logic [3:0] WAIT_INIT = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

    state_t     r_state;
    logic [3:0] r_wait_cnt;
    logic       r_busy;
    logic       r_done;

    assign o_state = r_state;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

    // State sequencing with busy/done registered alongside the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (i_empty) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (RD_LAT > 1) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= WAIT_INIT;
                    end else begin
                        r_state <= CMP;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= CMP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                CMP: begin
                    if (i_eq && !i_mode) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ISSUE;
                    end
                end
                DONE: begin
                    // Hold the result until the requester releases start
                    if (!i_start) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bsearch_engine.sv
// rtl/bsearch_engine.sv - binary-search engine over an external sorted synchronous RAM
module bsearch_engine
    import bsearch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W:0]   loc
);

    localparam logic [ADDR_W:0]   DEPTH_V   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_V     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ROOT_ADDR = ADDR_W'(DEPTH_V >> 1);

    logic [ADDR_W:0]   r_lo;
    logic [ADDR_W:0]   r_hi;
    logic [ADDR_W:0]   r_best;
    logic              r_hit;
    logic [DATA_W-1:0] r_key;
    logic              r_mode;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_found;
    logic [ADDR_W:0]   r_loc;

    state_t            w_state;
    cmp_t              w_cmp;
    logic              w_empty;
    logic [ADDR_W:0]   w_mid;
    logic [ADDR_W:0]   w_nlo;
    logic [ADDR_W:0]   w_nhi;
    logic [ADDR_W-1:0] w_nmid;

    assign w_empty = (r_lo == r_hi);
    assign w_mid   = (ADDR_W+1)'(calc_mid(32'(r_lo), 32'(r_hi)));
    assign w_nlo   = (w_cmp == GT) ? (w_mid + ONE_V) : r_lo;
    assign w_nhi   = ((w_cmp == LT) || ((w_cmp == EQ) && r_mode)) ? w_mid : r_hi;
    // Address of the next probe is prepared in CMP so it is stable throughout ISSUE
    assign w_nmid  = ADDR_W'(calc_mid(32'(w_nlo), 32'(w_nhi)));

    assign mem_addr = r_mem_addr;
    assign found    = r_found;
    assign loc      = r_loc;

    // Unsigned three-way compare of the latched key against the returned RAM word
    always_comb begin
        w_cmp = EQ;
        if (r_key < mem_q) begin
            w_cmp = LT;
        end else if (r_key > mem_q) begin
            w_cmp = GT;
        end
    end

    bsearch_engine_ctrl #(
        .RD_LAT (RD_LAT)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .i_start (start),
        .i_empty (w_empty),
        .i_eq    (w_cmp == EQ),
        .i_mode  (r_mode),
        .o_state (w_state),
        .o_busy  (busy),
        .o_done  (done)
    );

    // Search window, best-match tracking and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo       <= '0;
            r_hi       <= DEPTH_V;
            r_best     <= DEPTH_V;
            r_hit      <= 1'b0;
            r_key      <= '0;
            r_mode     <= 1'b0;
            r_mem_addr <= '0;
            r_found    <= 1'b0;
            r_loc      <= '0;
        end else begin
            case (w_state)
                IDLE: begin
                    r_lo    <= '0;
                    r_hi    <= DEPTH_V;
                    r_best  <= DEPTH_V;
                    r_hit   <= 1'b0;
                    r_found <= 1'b0;
                    r_loc   <= '0;
                    if (start) begin
                        r_key      <= key;
                        r_mode     <= mode;
                        r_mem_addr <= ROOT_ADDR;
                    end
                end
                ISSUE: begin
                    if (w_empty) begin
                        r_found <= r_hit;
                        r_loc   <= r_hit ? r_best : r_lo;
                    end
                end
                CMP: begin
                    r_lo       <= w_nlo;
                    r_hi       <= w_nhi;
                    r_mem_addr <= w_nmid;
                    if (w_cmp == EQ) begin
                        r_hit  <= 1'b1;
                        r_best <= w_mid;
                        if (!r_mode) begin
                            r_found <= 1'b1;
                            r_loc   <= w_mid;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bsearch_engine.sv
// tb/tb_bsearch_engine.sv - self-checking bench for bsearch_engine (32x8/lat1 and 256x8/lat2)
module tb_bsearch_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       start_a, mode_a, busy_a, done_a, found_a;
    logic [7:0] key_a, q_a;
    logic [4:0] addr_a;
    logic [5:0] loc_a;

    logic       start_b, mode_b, busy_b, done_b, found_b;
    logic [7:0] key_b, q_b, s1_b;
    logic [7:0] addr_b;
    logic [8:0] loc_b;

    logic [7:0] mem_a [32];
    logic [7:0] mem_b [256];

    always @(posedge clk) q_a <= mem_a[addr_a];

    always @(posedge clk) begin
        s1_b <= mem_b[addr_b];
        q_b  <= s1_b;
    end

    bsearch_engine #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .key(key_a), .mode(mode_a),
        .mem_addr(addr_a), .mem_q(q_a), .busy(busy_a), .done(done_a),
        .found(found_a), .loc(loc_a)
    );

    bsearch_engine #(.DATA_W(8), .ADDR_W(8), .RD_LAT(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .key(key_b), .mode(mode_b),
        .mem_addr(addr_b), .mem_q(q_b), .busy(busy_b), .done(done_b),
        .found(found_b), .loc(loc_b)
    );

    typedef struct {
        int key;
        bit mode;
        bit chk_res;
        bit fnd;
        int lmin;
        int lmax;
        int cmax;
        int cexact;
        int key_mid;
    } vec_t;

    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_cyc;

    function automatic vec_t mkv(input int key, input bit mode, input bit chk_res, input bit fnd,
                                 input int lmin, input int lmax, input int cmax, input int cexact,
                                 input int key_mid = -1);
        vec_t v;
        v.key = key; v.mode = mode; v.chk_res = chk_res; v.fnd = fnd;
        v.lmin = lmin; v.lmax = lmax; v.cmax = cmax; v.cexact = cexact; v.key_mid = key_mid;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Drive one search, wait (bounded) for done, compare against the queued expectation
    task automatic run(input bit which, input vec_t v, input string nm);
        vec_t exp;
        int   cyc;
        int   d, f, l;
        sb.push_back(v);
        if (!which) begin key_a = 8'(v.key); mode_a = v.mode; start_a = 1'b1; end
        else        begin key_b = 8'(v.key); mode_b = v.mode; start_b = 1'b1; end
        @(posedge clk); #1;
        cyc = 1;
        if (v.key_mid >= 0) begin
            if (!which) begin key_a = 8'(v.key_mid); mode_a = ~v.mode; end
            else        begin key_b = 8'(v.key_mid); mode_b = ~v.mode; end
        end
        d = which ? int'(done_b) : int'(done_a);
        while (d == 0 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            d = which ? int'(done_b) : int'(done_a);
        end
        f = which ? int'(found_b) : int'(found_a);
        l = which ? int'(loc_b) : int'(loc_a);
        exp = sb.pop_front();
        chk({nm, " done"}, d, 1);
        if (exp.chk_res) begin
            chk({nm, " found"}, f, int'(exp.fnd));
            chk_rng({nm, " loc"}, l, exp.lmin, exp.lmax);
        end
        chk_rng({nm, " cycles"}, cyc, 1, exp.cmax);
        if (exp.cexact > 0) chk({nm, " latency"}, cyc, exp.cexact);
        last_cyc = cyc;
        if (!which) start_a = 1'b0; else start_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_done_a(input string nm);
        int c;
        c = 0;
        while (!done_a && c < 60) begin
            @(posedge clk); #1;
            c++;
        end
        chk({nm, " done"}, int'(done_a), 1);
    endtask

    task automatic fill_odd();
        for (int i = 0; i < 32; i++) mem_a[i] = 8'(2 * i + 1);
    endtask

    vec_t tab_a [9];
    vec_t tab_d [5];
    int   max0, max1;

    initial begin
        tab_a[0] = mkv(33, 0, 1, 1, 16, 16, 20, 3);
        tab_a[1] = mkv(31, 0, 1, 1, 15, 15, 20, 0);
        tab_a[2] = mkv(1,  0, 1, 1,  0,  0, 20, 0);
        tab_a[3] = mkv(0,  0, 1, 0,  0,  0, 20, 0);
        tab_a[4] = mkv(64, 0, 1, 0, 32, 32, 20, 0);
        tab_a[5] = mkv(32, 0, 1, 0, 16, 16, 20, 0);
        tab_a[6] = mkv(33, 1, 1, 1, 16, 16, 20, 0);
        tab_a[7] = mkv(63, 0, 1, 1, 31, 31, 20, 0);
        tab_a[8] = mkv(31, 0, 1, 1, 15, 15, 20, 0, 0);
        tab_d[0] = mkv(5, 1, 1, 1, 20, 20, 20, 0);
        tab_d[1] = mkv(5, 0, 1, 1, 20, 23, 20, 0);
        tab_d[2] = mkv(7, 1, 1, 1, 28, 28, 20, 0);
        tab_d[3] = mkv(8, 1, 1, 0, 32, 32, 20, 0);
        tab_d[4] = mkv(0, 1, 1, 1,  0,  0, 20, 0);

        reset = 1'b1;
        start_a = 1'b0; key_a = '0; mode_a = 1'b0;
        start_b = 1'b0; key_b = '0; mode_b = 1'b0;
        fill_odd();
        for (int i = 0; i < 256; i++) mem_b[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", int'(busy_a), 0);
        chk("rst done", int'(done_a), 0);
        chk("rst found", int'(found_a), 0);
        chk("rst loc", int'(loc_a), 0);
        chk("rst mem_addr", int'(addr_a), 0);
        chk("rst busy_b", int'(busy_b), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (tab_a[i]) run(1'b0, tab_a[i], $sformatf("odd%0d", i));

        for (int i = 0; i < 32; i++) mem_a[i] = 8'(i / 4);
        foreach (tab_d[i]) run(1'b0, tab_d[i], $sformatf("dup%0d", i));

        // Unsorted contents: only bounded termination is required
        for (int i = 0; i < 32; i++) mem_a[i] = 8'($urandom_range(0, 255));
        run(1'b0, mkv(17, 0, 0, 0, 0, 0, 14, 0), "unsorted0");
        run(1'b0, mkv(200, 1, 0, 0, 0, 0, 14, 0), "unsorted1");
        fill_odd();

        // Reset while A sits in CMP
        key_a = 8'd0; mode_a = 1'b0; start_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst busy_before", int'(busy_a), 1);
        reset = 1'b1; start_a = 1'b0;
        @(posedge clk); #1;
        chk("midrst busy", int'(busy_a), 0);
        chk("midrst done", int'(done_a), 0);
        chk("midrst found", int'(found_a), 0);
        chk("midrst loc", int'(loc_a), 0);
        chk("midrst mem_addr", int'(addr_a), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        run(1'b0, mkv(31, 0, 1, 1, 15, 15, 20, 0), "after_rst");

        // Reset while B sits in WAIT
        key_b = 8'd100; mode_b = 1'b0; start_b = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; start_b = 1'b0;
        @(posedge clk); #1;
        chk("waitrst busy_b", int'(busy_b), 0);
        chk("waitrst done_b", int'(done_b), 0);
        chk("waitrst addr_b", int'(addr_b), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        run(1'b1, mkv(100, 0, 1, 1, 100, 100, 29, 0), "b_after_rst");

        // Handshake: done holds while start stays high, new search only after start drops
        key_a = 8'd33; mode_a = 1'b0; start_a = 1'b1;
        wait_done_a("hs1");
        chk("hs1 loc", int'(loc_a), 16);
        key_a = 8'd1;
        repeat (4) @(posedge clk);
        #1;
        chk("hs hold done", int'(done_a), 1);
        chk("hs hold busy", int'(busy_a), 0);
        chk("hs hold loc", int'(loc_a), 16);
        start_a = 1'b0;
        @(posedge clk); #1;
        chk("hs drop done", int'(done_a), 0);
        start_a = 1'b1;
        wait_done_a("hs2");
        chk("hs2 found", int'(found_a), 1);
        chk("hs2 loc", int'(loc_a), 0);
        // Reset while in DONE clears the held result
        key_a = 8'd33;
        start_a = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b1;
        wait_done_a("hs3");
        chk("hs3 loc", int'(loc_a), 16);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("donerst done", int'(done_a), 0);
        chk("donerst found", int'(found_a), 0);
        chk("donerst loc", int'(loc_a), 0);
        reset = 1'b0; start_a = 1'b0;
        @(posedge clk); #1;

        // Full sweep of the identity RAM in both modes
        max0 = 0; max1 = 0;
        for (int k = 0; k < 256; k++) begin
            run(1'b1, mkv(k, 0, 1, 1, k, k, 29, 0), $sformatf("sweep0_%0d", k));
            if (last_cyc > max0) max0 = last_cyc;
            run(1'b1, mkv(k, 1, 1, 1, k, k, 29, 0), $sformatf("sweep1_%0d", k));
            if (last_cyc > max1) max1 = last_cyc;
        end
        chk_rng("sweep max mode0", max0, 1, 29);
        chk("sweep max mode1", max1, 29);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
